// File: rtl/jtframe_joy_serial.sv
// Serial joystick reader for a 74HC165-style parallel-in/serial-out chain:
// drives load/clock, shifts JOYS*BITS bits per frame, publishes raw and frame-filtered buttons.
module jtframe_joy_serial #(
    parameter int JOYS   = 2,
    parameter int BITS   = 6,
    parameter int CLKDIV = 2,
    parameter int GAP    = 4,
    parameter int INVERT = 1,
    parameter int FILTER = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 joy_data,
    output logic                 joy_clk,
    output logic                 joy_load,
    output logic [JOYS*BITS-1:0] joys_raw,
    output logic [JOYS*BITS-1:0] joys,
    output logic                 frame_done
);
    localparam int N  = JOYS * BITS;
    localparam int DW = 16;
    localparam int BW = 7;
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLKDIV - 1);
    localparam logic [DW-1:0] GAP_LAST   = DW'(GAP - 1);
    localparam logic [BW-1:0] BIT_ALL    = BW'(N);
    localparam logic          INV_BIT    = 1'(INVERT);
    localparam logic [3:0]    FILTER_MIN = 4'(FILTER);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

    state_t        state_r;
    logic [DW-1:0] cnt_r;
    logic [BW-1:0] bit_cnt_r;
    logic [N-1:0]  sr_r;
    logic [3:0]    stable_r;

    logic          div_last_s;
    logic          gap_last_s;
    logic [N:0]    sr_shift_s;
    logic [3:0]    stable_nxt_s;

    // Phase-end flags, next shift image and the consecutive-identical-frame count
    always_comb begin
        div_last_s = (cnt_r == DIV_LAST);
        gap_last_s = (cnt_r == GAP_LAST);
        // one bit wider than the chain so the shift also works for a single-bit chain
        sr_shift_s = {sr_r, joy_data ^ INV_BIT};
        if (sr_r != joys_raw) begin
            stable_nxt_s = 4'd1;
        end else if (stable_r == 4'd15) begin
            stable_nxt_s = 4'd15;
        end else begin
            stable_nxt_s = stable_r + 4'd1;
        end
    end

    // Frame sequencer; every chain pin and output is a flop so pins stay glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bit_cnt_r  <= '0;
            sr_r       <= '0;
            stable_r   <= 4'd0;
            joy_clk    <= 1'b0;
            joy_load   <= 1'b1;
            joys_raw   <= '0;
            joys       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    joy_clk <= 1'b0;
                    cnt_r   <= '0;
                    if (en) begin
                        state_r  <= ST_LOAD;
                        joy_load <= 1'b0;
                    end else begin
                        joy_load <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    bit_cnt_r <= '0;
                    if (div_last_s) begin
                        state_r  <= ST_SHIFT_LO;
                        joy_load <= 1'b1;
                        cnt_r    <= '0;
                    end else begin
                        cnt_r <= cnt_r + DW'(1);
                    end
                end
                ST_SHIFT_LO: begin
                    if (div_last_s) begin
                        state_r   <= ST_SHIFT_HI;
                        joy_clk   <= 1'b1;
                        cnt_r     <= '0;
                        sr_r      <= sr_shift_s[N-1:0];
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                    end else begin
                        cnt_r <= cnt_r + DW'(1);
                    end
                end
                ST_SHIFT_HI: begin
                    if (div_last_s) begin
                        joy_clk <= 1'b0;
                        cnt_r   <= '0;
                        if (bit_cnt_r == BIT_ALL) begin
                            state_r    <= ST_GAP;
                            joys_raw   <= sr_r;
                            frame_done <= 1'b1;
                            stable_r   <= stable_nxt_s;
                            if (stable_nxt_s >= FILTER_MIN) begin
                                joys <= sr_r;
                            end
                        end else begin
                            state_r <= ST_SHIFT_LO;
                        end
                    end else begin
                        cnt_r <= cnt_r + DW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_last_s) begin
                        cnt_r <= '0;
                        if (en) begin
                            state_r  <= ST_LOAD;
                            joy_load <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + DW'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    joy_load <= 1'b1;
                    joy_clk  <= 1'b0;
                    cnt_r    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtframe_joy_serial.sv
// Randomized scoreboard bench: two readers (defaults, and 4x12 bits / CLKDIV=1 / GAP=1 /
// INVERT=0 / FILTER=3) each fed by a 74HC165 chain model.
module tb_jtframe_joy_serial;
    localparam int N0 = 12;
    localparam int N1 = 48;
    localparam int NB [2] = '{12, 48};
    localparam int CD [2] = '{2, 1};
    localparam int FL [2] = '{1, 3};
    localparam int FP [2] = '{2 * (1 + 2 * 12) + 4, 1 * (1 + 2 * 48) + 1};

    typedef struct packed {
        logic [47:0] raw;
        logic [47:0] joys;
    } exp_t;

    logic clk, rst, en;
    logic [1:0] jdata, jclk, jload, fdone;
    logic [N0-1:0] raw0, joys0;
    logic [N1-1:0] raw1, joys1;
    logic [47:0] raw_w [2];
    logic [47:0] joys_w [2];

    assign raw_w[0]  = {36'd0, raw0};
    assign raw_w[1]  = raw1;
    assign joys_w[0] = {36'd0, joys0};
    assign joys_w[1] = joys1;

    jtframe_joy_serial u_dut0 (
        .clk(clk), .rst(rst), .en(en), .joy_data(jdata[0]), .joy_clk(jclk[0]),
        .joy_load(jload[0]), .joys_raw(raw0), .joys(joys0), .frame_done(fdone[0])
    );

    jtframe_joy_serial #(
        .JOYS(4), .BITS(12), .CLKDIV(1), .GAP(1), .INVERT(0), .FILTER(3)
    ) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .joy_data(jdata[1]), .joy_clk(jclk[1]),
        .joy_load(jload[1]), .joys_raw(raw1), .joys(joys1), .frame_done(fdone[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int d, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    // Chain model: parallel load while load is low, shift towards the output on each clock rise
    logic [47:0]   pat [2];
    logic [N0-1:0] creg0;
    logic [N1-1:0] creg1;
    logic [1:0]    ck_prev;
    assign jdata[0] = creg0[N0-1] ^ 1'b1;
    assign jdata[1] = creg1[N1-1];

    always @(posedge clk) begin
        ck_prev <= jclk;
        if (!jload[0]) creg0 <= pat[0][N0-1:0];
        else if (jclk[0] && !ck_prev[0]) creg0 <= {creg0[N0-2:0], 1'b0};
        if (!jload[1]) creg1 <= pat[1];
        else if (jclk[1] && !ck_prev[1]) creg1 <= {creg1[N1-2:0], 1'b0};
    end

    // Reference model: when a frame's load starts, predict raw and filtered result
    logic [47:0] hist [2][$];
    exp_t        sbq [2][$];
    logic [47:0] joys_m [2];
    logic [1:0]  ld_prev = 2'b11;
    int          run_m;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                hist[d].delete();
                joys_m[d] = 48'd0;
                ld_prev[d] = 1'b1;
            end else begin
                if (!jload[d] && ld_prev[d]) begin
                    hist[d].push_back(pat[d]);
                    if (hist[d].size() > 16) void'(hist[d].pop_front());
                    run_m = 0;
                    for (int i = hist[d].size() - 1; i >= 0; i--) begin
                        if (hist[d][i] != pat[d]) break;
                        run_m++;
                    end
                    if (run_m >= FL[d]) joys_m[d] = pat[d];
                    sbq[d].push_back('{raw: pat[d], joys: joys_m[d]});
                end
                ld_prev[d] = jload[d];
            end
        end
    end

    // Stimulus: pick what each chain holds for the next frame
    int fcount [2] = '{0, 0};

    function automatic logic [47:0] next_pattern(input int d, input int k, input logic [47:0] cur);
        logic [47:0] r;
        r = 48'({$urandom, $urandom});
        if (d == 0) begin
            if (k < 3) return 48'hA5C;
            return ($urandom_range(0, 1) == 0) ? cur : (r & 48'hFFF);
        end
        case (k)
            1, 3, 4, 5:  return 48'h5A3C_9E01_7BD4;
            2:           return 48'h5A3C_9E01_7BD5;
            6, 7, 8:     return 48'h0000_0000_0001;
            9, 10, 11:   return 48'h8000_0000_0000;
            12, 13, 14:  return 48'hFFFF_FFFF_FFFF;
            default:     return ($urandom_range(0, 2) != 0) ? cur : r;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst && fdone[d]) begin
                fcount[d] = fcount[d] + 1;
                pat[d] = next_pattern(d, fcount[d], pat[d]);
            end
        end
    end

    // Monitor: on every frame_done pop the prediction and check frame shape and period
    int   cyc = 0;
    int   lo_cnt [2], hi_cnt [2], rises [2], hi_run [2], prev_fd [2];
    logic [1:0] prev_ok = 2'b00, en_gap = 2'b00, ck_m = 2'b00;
    exp_t mon_e;

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                sbq[d].delete();
                lo_cnt[d] = 0; hi_cnt[d] = 0; rises[d] = 0; hi_run[d] = 0;
                prev_ok[d] = 1'b0; ck_m[d] = 1'b0; en_gap[d] = 1'b0;
            end else begin
                if (!en) en_gap[d] = 1'b1;
                if (!jload[d]) lo_cnt[d]++;
                if (jclk[d]) begin
                    hi_cnt[d]++;
                    hi_run[d]++;
                    if (!ck_m[d]) rises[d]++;
                end else if (hi_run[d] != 0) begin
                    check("clk_high_len", d, 48'(hi_run[d]), 48'(CD[d]));
                    hi_run[d] = 0;
                end
                ck_m[d] = jclk[d];
                if (fdone[d]) begin
                    if (sbq[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame_done dut%0d: got a frame_done, expected none", d);
                    end else begin
                        mon_e = sbq[d].pop_front();
                        check("joys_raw", d, raw_w[d], mon_e.raw);
                        check("joys", d, joys_w[d], mon_e.joys);
                    end
                    check("clk_pulses", d, 48'(rises[d]), 48'(NB[d]));
                    check("clk_high_total", d, 48'(hi_cnt[d]), 48'(CD[d] * NB[d]));
                    check("load_low_len", d, 48'(lo_cnt[d]), 48'(CD[d]));
                    if (prev_ok[d] && !en_gap[d])
                        check("frame_period", d, 48'(cyc - prev_fd[d]), 48'(FP[d]));
                    prev_fd[d] = cyc;
                    prev_ok[d] = 1'b1;
                    en_gap[d] = 1'b0;
                    lo_cnt[d] = 0; hi_cnt[d] = 0; rises[d] = 0;
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_joy_load"}, d, 48'(jload[d]), 48'd1);
            check({tag, "_joy_clk"}, d, 48'(jclk[d]), 48'd0);
            check({tag, "_frame_done"}, d, 48'(fdone[d]), 48'd0);
            check({tag, "_joys_raw"}, d, raw_w[d], 48'd0);
            check({tag, "_joys"}, d, joys_w[d], 48'd0);
        end
    endtask

    task automatic wait_frames(input int t0, input int t1, input int budget);
        int k = 0;
        while ((fcount[0] < t0 || fcount[1] < t1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frames_reached", 0, 48'(k < budget), 48'd1);
    endtask

    int base0;
    int k;
    logic idle_ok [2];

    initial begin
        rst = 1'b1;
        en = 1'b0;
        pat[0] = 48'hA5C;
        pat[1] = 48'h5A3C_9E01_7BD4;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        wait_frames(12, 15, 3000);

        // Drop enable in the middle of a shift of dut0
        k = 0;
        while (!jclk[0] && k < 200) begin @(negedge clk); k++; end
        check("found_shift", 0, 48'(jclk[0]), 48'd1);
        base0 = fcount[0];
        en = 1'b0;
        repeat (250) @(negedge clk);
        check("en_drop_completes", 0, 48'(fcount[0] - base0), 48'd1);
        idle_ok[0] = 1'b1;
        idle_ok[1] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                if (jload[d] !== 1'b1 || jclk[d] !== 1'b0) idle_ok[d] = 1'b0;
        end
        check("idle_pins", 0, 48'(idle_ok[0]), 48'd1);
        check("idle_pins", 1, 48'(idle_ok[1]), 48'd1);
        en = 1'b1;
        @(negedge clk);
        check("load_after_en", 0, 48'(jload[0]), 48'd0);
        check("load_after_en", 1, 48'(jload[1]), 48'd0);
        wait_frames(fcount[0] + 4, fcount[1] + 2, 2000);

        // Asynchronous reset during bit 7 of a dut0 frame
        k = 0;
        while (jload[0] && k < 200) begin @(negedge clk); k++; end
        check("found_load", 0, 48'(jload[0]), 48'd0);
        k = 0;
        base0 = 0;
        while (base0 < 7 && k < 200) begin
            @(negedge clk);
            k++;
            if (jclk[0] && !ck_m[0]) base0++;
        end
        check("found_bit7", 0, 48'(base0), 48'd7);
        #3 rst = 1'b1;
        #1 check_reset("mid_reset");
        #30 rst = 1'b0;
        wait_frames(fcount[0] + 5, fcount[1] + 3, 2000);

        en = 1'b0;
        repeat (300) @(negedge clk);
        check("sb_drained", 0, 48'(sbq[0].size()), 48'd0);
        check("sb_drained", 1, 48'(sbq[1].size()), 48'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
